// File: rtl/hrmf_seq.sv
// Input sequencer and twiddle-address generator feeding the HRMF radix-16 stage.
// Optional gap detection is built when HRMF_SEQ_GAPCHK_EN is defined; otherwise ERR is tied low.
module hrmf_seq #(
  parameter int LOG2N   = 8,
  parameter int MTU_LAT = 3,
  parameter int TF_LAT  = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [63:0]      IN_D0,
  input  logic [63:0]      IN_D1,
  input  logic [63:0]      IN_D2,
  input  logic [63:0]      IN_D3,
  output logic [63:0]      D0,
  output logic [63:0]      D1,
  output logic [63:0]      D2,
  output logic [63:0]      D3,
  output logic [1:0]       SEL_ROTATOR0,
  output logic [1:0]       SEL_MTU4X4,
  output logic [LOG2N-1:0] TF_ADDR0,
  output logic [LOG2N-1:0] TF_ADDR1,
  output logic [LOG2N-1:0] TF_ADDR2,
  output logic [LOG2N-1:0] TF_ADDR3,
  output logic             OUT_VALID,
  output logic             OUT_LAST,
  output logic             ERR
);

  // state | meaning
  // IDLE  | no frame in flight, phase held at 0
  // RUN   | loading beats of a frame, phase advances every cycle
  // DRAIN | D* driven 0 while the delay line empties; a beat at phase 0 restarts RUN
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int FW = (LOG2N > 4) ? LOG2N - 4 : 1;
  localparam int K  = MTU_LAT - TF_LAT;
  localparam logic [FW-1:0] FRAME_MAX = FW'((1 << (LOG2N - 4)) - 1);

  state_t          state, state_nxt;
  logic [1:0]      phase, phase_nxt;
  logic            accept, load, gap, line_empty;
  logic [LOG2N-1:0] tf_base;

  // Index 0 is the D* stage; index MTU_LAT lines up with HRMF Q*.
  logic [1:0]    q_dly [0:MTU_LAT];
  logic [FW-1:0] f_dly [0:MTU_LAT];
  logic          v_dly [0:MTU_LAT];

  assign IN_READY = ~RST;
  assign accept   = IN_VALID & IN_READY;

  always_comb begin
    line_empty = 1'b1;
    for (int k = 0; k <= MTU_LAT; k++) begin
      if (v_dly[k]) line_empty = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    load      = 1'b0;
    gap       = 1'b0;
    case (state)
      IDLE: begin
        phase_nxt = 2'd0;
        if (accept) begin
          load      = 1'b1;
          phase_nxt = 2'd1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        load      = 1'b1;
        gap       = ~IN_VALID;
        phase_nxt = phase + 2'd1;
        if (phase == 2'd3) state_nxt = DRAIN;
      end
      DRAIN: begin
        phase_nxt = phase + 2'd1;
        if (phase == 2'd0) begin
          if (accept) begin
            load      = 1'b1;
            state_nxt = RUN;
          end else if (line_empty) begin
            state_nxt = IDLE;
            phase_nxt = 2'd0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      phase <= 2'd0;
      D0    <= '0;
      D1    <= '0;
      D2    <= '0;
      D3    <= '0;
      for (int k = 0; k <= MTU_LAT; k++) begin
        q_dly[k] <= '0;
        f_dly[k] <= '0;
        v_dly[k] <= 1'b0;
      end
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      D0       <= (load && !gap) ? IN_D0 : '0;
      D1       <= (load && !gap) ? IN_D1 : '0;
      D2       <= (load && !gap) ? IN_D2 : '0;
      D3       <= (load && !gap) ? IN_D3 : '0;
      v_dly[0] <= load;
      q_dly[0] <= phase;
      // f_dly[0] is the frame of the beat on D*, so it steps as the phase-3 beat leaves.
      if (state_nxt == IDLE && state != IDLE)
        f_dly[0] <= '0;
      else if (v_dly[0] && q_dly[0] == 2'd3)
        f_dly[0] <= (f_dly[0] == FRAME_MAX) ? '0 : f_dly[0] + 1'b1;
      for (int k = 1; k <= MTU_LAT; k++) begin
        q_dly[k] <= q_dly[k-1];
        f_dly[k] <= f_dly[k-1];
        v_dly[k] <= v_dly[k-1];
      end
    end
  end

  assign SEL_ROTATOR0 = q_dly[0];
  assign SEL_MTU4X4   = q_dly[0];

  // 4*f+q never exceeds N, so lane multiples wrap naturally at LOG2N bits.
  assign tf_base  = LOG2N'({f_dly[K], q_dly[K]});
  assign TF_ADDR0 = '0;
  assign TF_ADDR1 = v_dly[K] ? tf_base : '0;
  assign TF_ADDR2 = v_dly[K] ? LOG2N'(tf_base << 1) : '0;
  assign TF_ADDR3 = v_dly[K] ? LOG2N'(tf_base + (tf_base << 1)) : '0;

  assign OUT_VALID = v_dly[MTU_LAT];
  assign OUT_LAST  = v_dly[MTU_LAT] && (q_dly[MTU_LAT] == 2'd3) && (f_dly[MTU_LAT] == FRAME_MAX);

`ifdef HRMF_SEQ_GAPCHK_EN
  logic err;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)      err <= 1'b0;
    else if (gap) err <= 1'b1;
  end
  assign ERR = err;
`else
  assign ERR = 1'b0;
`endif

endmodule
